cpa_resolve_stage: RTL
======================

CPA_RESOLVE_STAGE -- requirements
Module: cpa_resolve_stage

Interface
REQ-001 Parameter WIDTH, default 8: width of the incoming carry-save sum and carry vectors; even, at least 4.
REQ-002 Parameter APPROX, default 0: 0 selects an exact final addition; 1 selects approximate low bits.
REQ-003 Parameter LSB_APPROX, default 2: number of approximate low result bits when APPROX=1; range 1 to WIDTH/2-1.
REQ-004 Parameter IDLE_CYCLES, default 4: consecutive idle cycles before a clock-gate request; range 1 to 255.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  sum/carry pair presented.
REQ-008 in_ready  output  1  stage accepts the pair this cycle.
REQ-009 sum_in  input  WIDTH  carry-save sum vector.
REQ-010 carry_in  input  WIDTH  carry-save carry vector, weight of bit i = 2^(i+1).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  WIDTH+2  resolved sum_in + 2*carry_in.
REQ-014 gate_req  output  1  registered request to gate the upstream CSA clock.

Function
REQ-015 A transfer occurs on any edge with in_valid=1 and in_ready=1; an output transfer occurs with out_valid=1 and out_ready=1.
REQ-016 Stage A (H=WIDTH/2) shall compute low = sum_in[H-1:0] + {carry_in[H-2:0],0}, register low[H-1:0], its carry-out c_lo, sum_in[WIDTH-1:H] and carry_in[WIDTH-1:H-1].
REQ-017 Stage B shall compute the upper result bits as the registered upper sum + registered upper carry + c_lo, producing result[WIDTH+1:H].
REQ-018 Latency is exactly 2 cycles from input transfer to out_valid=1 with no stall; throughput is 1 pair per cycle.
REQ-019 Stage B advances when it is empty or its output transfers; stage A advances when it is empty or stage B advances; in_ready = !A_valid or B advances.
REQ-020 While out_valid=1 and out_ready=0, result and out_valid shall hold stable; no data is lost or duplicated.
REQ-021 With APPROX=1, result[LSB_APPROX-1:0] = bitwise OR of sum_in and {carry_in,0} in those bits; no carry propagates out of that region; the remaining bits are exact.
REQ-022 The idle counter increments (saturating at IDLE_CYCLES) on each cycle with in_valid=0, stage A empty and stage B empty; otherwise it clears to 0.
REQ-023 gate_req is registered; it is 1 when the counter equals IDLE_CYCLES and drops to 0 on the first edge after in_valid=1.
REQ-024 gate_req shall never gate this block: in_ready is independent of gate_req.

Reset
REQ-025 On rst=1, both stage valids, out_valid, result, the idle counter and gate_req shall clear to 0 immediately; in_ready is 1 after reset.
REQ-026 Reset mid-operation discards in-flight pairs; the first post-reset transfer behaves as after power-up.

Structure
REQ-027 The shared multiplier package holds the WIDTH, LSB_APPROX and IDLE_CYCLES default constants and the result-width expression WIDTH+2.
REQ-028 The per-stage addition is one sub-module, param_rca (parameterised ripple-carry adder built from param_full_adder), instantiated once per stage.

Verification
REQ-029 WIDTH=8, APPROX=0: sum_in=0xFF, carry_in=0xFF, out_ready=1 -> result=0x2FD exactly 2 cycles after the transfer.
REQ-030 APPROX=1, LSB_APPROX=2: sum_in=0x03, carry_in=0x01 -> result=0x003 (exact value would be 0x005).
REQ-031 Back-to-back stream of 0x10/0x01, 0x20/0x02, 0x30/0x03 with out_ready=0 for 3 cycles -> in_ready=0 once both stages are full; results 0x12, 0x24, 0x36 come out in order with none lost.
REQ-032 Idle for 4 cycles after reset -> gate_req=1 on the 4th edge; in_valid=1 -> gate_req=0 on the next edge; the pair is still accepted.
REQ-033 rst pulse while both stages are valid -> out_valid=0 immediately; the next pair 0x01/0x01 yields result=0x003.
REQ-034 Random sum_in/carry_in, 10k pairs with random out_ready -> every result matches sum_in + 2*carry_in (APPROX=0).

Source files
------------

// File: rtl/cpa_resolve_stage_pkg.sv
// Shared constants for the carry-propagate resolve stage that closes the
// multiplier's carry-save tree.
package cpa_resolve_stage_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int LSB_APPROX_DEF  = 2;
    localparam int IDLE_CYCLES_DEF = 4;
    localparam int IDLE_CNT_W      = 8;

    // Sum plus doubled carry of two WIDTH-bit vectors needs two extra bits.
    function automatic int res_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/param_full_adder.sv
// One-bit full adder, the cell of the ripple-carry adder.
module param_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/param_rca.sv
// N-bit ripple-carry adder built from param_full_adder cells.
module param_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        param_full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[N];

endmodule

// File: rtl/cpa_resolve_stage.sv
// Two-stage pipelined resolution of a carry-save pair (sum + 2*carry) with
// valid/ready handshake, optional approximate low bits and an idle clock-gate request.
module cpa_resolve_stage
    import cpa_resolve_stage_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int APPROX      = 0,
    parameter int LSB_APPROX  = LSB_APPROX_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            sum_in,
    input  logic [WIDTH-1:0]            carry_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [res_width(WIDTH)-1:0] result,
    output logic                        gate_req
);

    localparam int H    = WIDTH / 2;
    localparam int RW   = res_width(WIDTH);
    localparam int NAPX = (APPROX != 0) ? LSB_APPROX : 0;
    localparam logic [H-1:0]          APX_MASK = H'((1 << NAPX) - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_CYCLES);

    logic a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic a_adv, b_adv;
    logic [H-1:0] lo_q, lo_d, sum_hi_q, sum_hi_d;
    logic [H:0]   carry_hi_q, carry_hi_d;
    logic         c_lo_q, c_lo_d;
    logic [RW-1:0] result_q, result_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic gate_req_q, gate_req_d;

    logic [H-1:0] lo_a_op, lo_b_op, lo_sum, lo_bits;
    logic         lo_cout;
    logic [H:0]   hi_sum;
    logic         hi_cout;

    assign lo_a_op = sum_in[H-1:0];
    assign lo_b_op = {carry_in[H-2:0], 1'b0};

    // Approximate bits are zeroed at the adder so no carry leaves that region;
    // they are then replaced by the OR of the operands.
    param_rca #(.N(H)) u_rca_lo (
        .a   (lo_a_op & ~APX_MASK),
        .b   (lo_b_op & ~APX_MASK),
        .cin (1'b0),
        .sum (lo_sum),
        .cout(lo_cout)
    );

    assign lo_bits = (lo_sum & ~APX_MASK) | ((lo_a_op | lo_b_op) & APX_MASK);

    param_rca #(.N(H + 1)) u_rca_hi (
        .a   ({1'b0, sum_hi_q}),
        .b   (carry_hi_q),
        .cin (c_lo_q),
        .sum (hi_sum),
        .cout(hi_cout)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        b_adv      = !b_valid_q || out_ready;
        a_adv      = !a_valid_q || b_adv;

        a_valid_d  = a_valid_q;
        lo_d       = lo_q;
        c_lo_d     = c_lo_q;
        sum_hi_d   = sum_hi_q;
        carry_hi_d = carry_hi_q;
        if (a_adv) begin
            a_valid_d  = in_valid;
            lo_d       = lo_bits;
            c_lo_d     = lo_cout;
            sum_hi_d   = sum_in[WIDTH-1:H];
            carry_hi_d = carry_in[WIDTH-1:H-1];
        end

        b_valid_d = b_valid_q;
        result_d  = result_q;
        if (b_adv) begin
            b_valid_d = a_valid_q;
            result_d  = {hi_cout, hi_sum, lo_q};
        end

        idle_cnt_d = '0;
        if (!in_valid && !a_valid_q && !b_valid_q) begin
            idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
        gate_req_d = (idle_cnt_d == IDLE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            lo_q       <= '0;
            c_lo_q     <= 1'b0;
            sum_hi_q   <= '0;
            carry_hi_q <= '0;
            result_q   <= '0;
            idle_cnt_q <= '0;
            gate_req_q <= 1'b0;
        end else begin
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            lo_q       <= lo_d;
            c_lo_q     <= c_lo_d;
            sum_hi_q   <= sum_hi_d;
            carry_hi_q <= carry_hi_d;
            result_q   <= result_d;
            idle_cnt_q <= idle_cnt_d;
            gate_req_q <= gate_req_d;
        end
    end

    assign in_ready  = a_adv;
    assign out_valid = b_valid_q;
    assign result    = result_q;
    assign gate_req  = gate_req_q;

endmodule
